multicycle_ctrl: RTL and testbench

- Multi-cycle RV64I control sequencer that drives the instruction-parser and register-file datapath.
- Accepts one 32-bit instruction at a time through a valid/ready handshake and holds it in an internal IR.
- Steps the instruction through DECODE, EXEC, MEM and WB, generating register-file write enable, memory strobes, ALU controls and PC update pulses.
- Sits between instruction supply and the datapath top level; owns the RegWrite decision.

---
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV64I control sequencer (IDLE/DECODE/EXEC/MEM/WB/TRAP).
// Optional MEM watchdog is enabled by defining MEMCTRL_TIMEOUT_EN.
module multicycle_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instruction,
    output logic             instr_ready,
    input  logic             mem_ready,
    input  logic             trap_clear,
    output logic [31:0]      ir_out,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             branch_en,
    output logic             pc_write,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    logic [6:0] opcode;
    logic       is_r, is_i, is_load, is_store, is_branch, is_legal;
    logic       rd_nonzero;
    logic       tmo_hit;

    assign opcode     = ir_q[6:0];
    assign is_r       = (opcode == 7'b0110011);
    assign is_i       = (opcode == 7'b0010011);
    assign is_load    = (opcode == 7'b0000011);
    assign is_store   = (opcode == 7'b0100011);
    assign is_branch  = (opcode == 7'b1100011);
    assign is_legal   = is_r | is_i | is_load | is_store | is_branch;
    assign rd_nonzero = (ir_q[11:7] != 5'd0);

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    // Held at zero outside MEM, so it always starts from zero on MEM entry.
    always_comb begin
        tmo_d   = tmo_q;
        tmo_hit = 1'b0;
        if (state_q != StMem) begin
            tmo_d = '0;
        end else if (!mem_ready) begin
            tmo_d   = tmo_q + 1'b1;
            tmo_hit = (tmo_d == TmoW'(MEM_TIMEOUT));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        retire      = 1'b0;
        instr_ready = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src_b   = 1'b0;
        alu_op      = 2'b00;
        branch_en   = 1'b0;
        pc_write    = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            StIdle: begin
                // Gated by reset so ready stays low while reset is held.
                instr_ready = reset;
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = is_legal ? StExec : StTrap;
            end
            StExec: begin
                if (is_r || is_i) begin
                    alu_op    = 2'b10;
                    alu_src_b = is_i;
                    state_d   = StWb;
                end else if (is_load || is_store) begin
                    alu_op    = 2'b00;
                    alu_src_b = 1'b1;
                    state_d   = StMem;
                end else if (is_branch) begin
                    alu_op    = 2'b01;
                    branch_en = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    state_d   = StIdle;
                end else begin
                    state_d = StIdle;
                end
            end
            StMem: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        state_d = StWb;
                    end else begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = StIdle;
                    end
                end else if (tmo_hit) begin
                    state_d = StTrap;
                end
            end
            StWb: begin
                reg_write = rd_nonzero;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = StIdle;
            end
            StTrap: begin
                illegal = 1'b1;
                if (trap_clear) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            if (retire) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    assign ir_out  = ir_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: a per-instruction trace model
// builds the expected outputs of every cycle, one compare process checks them at negedge.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        instr_ready;
    logic        mem_ready;
    logic        trap_clear;
    logic [31:0] ir_out;
    logic        reg_write, mem_read, mem_write, alu_src_b, branch_en, pc_write, illegal;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] retired;

    multicycle_ctrl #(
        .CNT_W       (32),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .instr_ready (instr_ready),
        .mem_ready   (mem_ready),
        .trap_clear  (trap_clear),
        .ir_out      (ir_out),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .branch_en   (branch_en),
        .pc_write    (pc_write),
        .illegal     (illegal),
        .state       (state),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        rdy;
        logic [31:0] ir;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        srcb;
        logic [1:0]  aop;
        logic        br;
        logic        pcw;
        logic        ill;
        logic [31:0] ret;
    } obs_t;

    // Instruction classes of the model
    localparam int ClsR = 0, ClsI = 1, ClsLd = 2, ClsSt = 3, ClsBr = 4, ClsBad = 5;

    int          checks = 0;
    int          errors = 0;
    obs_t        exp_o;
    logic        chk_en = 1'b0;
    logic [31:0] m_ir   = 32'd0;
    logic [31:0] m_ret  = 32'd0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, want);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.st   = state;
        o.rdy  = instr_ready;
        o.ir   = ir_out;
        o.rw   = reg_write;
        o.mr   = mem_read;
        o.mw   = mem_write;
        o.srcb = alu_src_b;
        o.aop  = alu_op;
        o.br   = branch_en;
        o.pcw  = pc_write;
        o.ill  = illegal;
        o.ret  = retired;
        return o;
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t o = '0;
        o.st  = st;
        o.rdy = (st == 3'd0);
        o.ir  = m_ir;
        o.ret = m_ret;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int cls_of(input logic [31:0] ins);
        case (ins[6:0])
            7'h33:   return ClsR;
            7'h13:   return ClsI;
            7'h03:   return ClsLd;
            7'h23:   return ClsSt;
            7'h63:   return ClsBr;
            default: return ClsBad;
        endcase
    endfunction

    function automatic logic [31:0] gen(input int c);
        logic [31:0] r = $urandom;
        case (c)
            ClsR:    r[6:0] = 7'h33;
            ClsI:    r[6:0] = 7'h13;
            ClsLd:   r[6:0] = 7'h03;
            ClsSt:   r[6:0] = 7'h23;
            ClsBr:   r[6:0] = 7'h63;
            default: while (cls_of(r) != ClsBad) r[6:0] = 7'($urandom);
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) chk("trace", 96'(dut_obs()), 96'(exp_o));
    end

    task automatic step(input obs_t e, input logic v, input logic [31:0] ins,
                        input logic mr, input logic tc);
        @(posedge clk);
        #1;
        instr_valid = v;
        instruction = ins;
        mem_ready   = mr;
        trap_clear  = tc;
        exp_o       = e;
        chk_en      = 1'b1;
    endtask

    task automatic idle_cycle();
        step(base(3'd0), 1'b0, $urandom, rb(), rb());
    endtask

    // Whole life of one instruction from the IDLE handshake back to IDLE.
    task automatic run_instr(input logic [31:0] ins, input int wt);
        obs_t e;
        int   c = cls_of(ins);
        step(base(3'd0), 1'b1, ins, rb(), rb());
        m_ir = ins;
        step(base(3'd2), rb(), $urandom, rb(), rb());
        if (c == ClsBad) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                e = base(3'd6); e.ill = 1'b1;
                step(e, 1'b1, $urandom, rb(), 1'b0);
            end
            e = base(3'd6); e.ill = 1'b1;
            step(e, 1'b0, $urandom, rb(), 1'b1);
            return;
        end
        e = base(3'd3);
        case (c)
            ClsR:    e.aop = 2'b10;
            ClsI:    begin e.aop = 2'b10; e.srcb = 1'b1; end
            ClsBr:   begin e.aop = 2'b01; e.br = 1'b1; e.pcw = 1'b1; end
            default: begin e.aop = 2'b00; e.srcb = 1'b1; end
        endcase
        step(e, rb(), $urandom, rb(), rb());
        if (c == ClsBr) begin
            m_ret++;
            return;
        end
        if (c == ClsLd || c == ClsSt) begin
            for (int i = 0; i <= wt; i++) begin
                e = base(3'd4);
                e.mr = (c == ClsLd);
                e.mw = (c == ClsSt);
                e.pcw = (c == ClsSt) && (i == wt);
                step(e, rb(), $urandom, (i == wt), rb());
            end
            if (c == ClsSt) begin
                m_ret++;
                return;
            end
        end
        e = base(3'd5);
        e.rw  = (ins[11:7] != 5'd0);
        e.pcw = 1'b1;
        step(e, rb(), $urandom, rb(), rb());
        m_ret++;
    endtask

    initial begin
        obs_t e;
        reset       = 1'b0;
        instr_valid = 1'b0;
        instruction = 32'd0;
        mem_ready   = 1'b0;
        trap_clear  = 1'b0;
        #12;
        chk("reset_outputs", 96'(dut_obs()), 96'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready_after_reset", 96'(instr_ready), 96'd1);

        // Directed program with hand-computed retire counts and IR values.
        run_instr(32'h002081B3, 0);
        idle_cycle();
        @(negedge clk);
        chk("add_retired", 96'(retired), 96'd1);
        chk("add_ir", 96'(ir_out), 96'h002081B3);
        run_instr(32'h00500013, 0);
        idle_cycle();
        @(negedge clk);
        chk("addi_x0_retired", 96'(retired), 96'd2);
        run_instr(32'h0080B283, 3);
        run_instr(32'h0050B423, 2);
        idle_cycle();
        @(negedge clk);
        chk("ld_sd_retired", 96'(retired), 96'd4);
        run_instr(32'h00208463, 0);
        run_instr(32'h0000007F, 0);
        idle_cycle();
        @(negedge clk);
        chk("trap_retired", 96'(retired), 96'd5);
        chk("trap_ir", 96'(ir_out), 96'h0000007F);
        chk("trap_cleared", 96'(illegal), 96'd0);

        for (int n = 0; n < 250; n++) begin
            int c = (n % 8 == 7) ? ClsBad : int'($urandom_range(0, 4));
            run_instr(gen(c), int'($urandom_range(0, 4)));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) idle_cycle();
        end

        // Reset asserted while a load waits in MEM.
        step(base(3'd0), 1'b1, 32'h0080B283, 1'b0, 1'b0);
        m_ir = 32'h0080B283;
        step(base(3'd2), 1'b0, 32'd0, 1'b0, 1'b0);
        e = base(3'd3); e.srcb = 1'b1;
        step(e, 1'b0, 32'd0, 1'b0, 1'b0);
        e = base(3'd4); e.mr = 1'b1;
        step(e, 1'b0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk_en    = 1'b0;
        mem_ready = 1'b1;
        reset     = 1'b0;
        #1;
        chk("reset_in_mem", 96'(dut_obs()), 96'd0);
        @(negedge clk);
        reset = 1'b1;
        m_ir  = 32'd0;
        m_ret = 32'd0;
        for (int k = 0; k < 3; k++) idle_cycle();
        run_instr(32'h002081B3, 0);
        idle_cycle();
        @(negedge clk);
        chk("retired_after_reset", 96'(retired), 96'd1);

`ifdef MEMCTRL_TIMEOUT_EN
        step(base(3'd0), 1'b1, 32'h0080B283, 1'b0, 1'b0);
        m_ir = 32'h0080B283;
        step(base(3'd2), 1'b0, 32'd0, 1'b0, 1'b0);
        e = base(3'd3); e.srcb = 1'b1;
        step(e, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            e = base(3'd4); e.mr = 1'b1;
            step(e, 1'b0, 32'd0, 1'b0, 1'b0);
        end
        e = base(3'd6); e.ill = 1'b1;
        step(e, 1'b0, 32'd0, 1'b0, 1'b0);
        step(e, 1'b0, 32'd0, 1'b0, 1'b1);
        idle_cycle();
        @(negedge clk);
        chk("timeout_retired", 96'(retired), 96'd1);
`endif

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
